// File: rtl/bus_src_decoder_if.sv
// Request/enable bundle between the control unit and the bus-source decoder.
// The control unit drives the master side; the decoder implements the slave side.
interface bus_src_decoder_if #(
    parameter int unsigned CODE_W  = 5,
    parameter int unsigned NUM_SRC = 24
);
    logic [CODE_W-1:0]  code;
    logic               code_valid;
    logic               ready;
    logic [NUM_SRC-1:0] src_sel;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output code, code_valid,
        input  ready, src_sel, busy, done, err
    );

    modport slave (
        input  code, code_valid,
        output ready, src_sel, busy, done, err
    );
endinterface

// File: rtl/bus_src_decoder.sv
// Decodes a bus-source code into a registered one-hot enable held for HOLD_CYCLES clocks.
// Optional macro BUS_SRC_DECODE_B2B_EN: accept a new request in the last drive cycle.
module bus_src_decoder #(
    parameter int unsigned CODE_W      = 5,
    parameter int unsigned NUM_SRC     = 24,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    bus_src_decoder_if.slave bus
);

    localparam int unsigned     CNT_W        = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic            LAST_ON_LOAD = (HOLD_CYCLES == 1);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NUM_SRC-1:0] sel, sel_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;
    logic               err_q, err_nx;

    logic [CODE_W-1:0]  code_c;
    logic               ready_c;
    logic               legal_c;
    logic               accept_c;

    assign code_c  = bus.code;
    assign legal_c = (32'(code_c) < NUM_SRC);

`ifdef BUS_SRC_DECODE_B2B_EN
    // Last drive cycle may hand the bus straight to the next source.
    assign ready_c = (state == IDLE) || ((state == DRIVE) && (cnt == '0));
`else
    assign ready_c = (state == IDLE);
`endif

    assign accept_c = bus.code_valid && ready_c;

    // Next-state and next-output decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        if (state == DRIVE) begin
            if (cnt != '0) begin
                cnt_nx  = cnt - CNT_W'(1);
                done_nx = (cnt == CNT_W'(1));
            end else begin
                state_nx = IDLE;
                sel_nx   = '0;
            end
        end

        // A request can only be accepted when the bus is free or about to be.
        if (accept_c) begin
            if (legal_c) begin
                state_nx = DRIVE;
                cnt_nx   = CNT_LOAD;
                sel_nx   = NUM_SRC'(1) << code_c;
                done_nx  = LAST_ON_LOAD;
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
                sel_nx   = '0;
                err_nx   = 1'b1;
            end
        end

        busy_nx = |sel_nx;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sel    <= sel_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    assign bus.ready   = ready_c;
    assign bus.src_sel = sel;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bus_src_decoder.sv
// Scoreboard bench: two decoders (HOLD_CYCLES 1 and 3) driven with directed and random requests.
// Expected transfers are queued on acceptance; a monitor pops and checks them from the outputs.
module tb_bus_src_decoder;

    localparam int unsigned HOLD0 = 1;
    localparam int unsigned HOLD1 = 3;
`ifdef BUS_SRC_DECODE_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef struct {
        logic [4:0] code;
        bit         legal;
    } exp_t;

    logic        clock;
    logic        clear_n;
    logic [4:0]  code_d [2];
    logic        vld_d  [2];
    logic        rdy_o  [2];
    logic [23:0] sel_o  [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o  [2];

    int   checks = 0;
    int   errors = 0;
    exp_t q [2][$];
    int   rem [2];
    bit   inx [2];
    bit   last_done [2];
    int   cnt [2];
    logic [23:0] cur [2];

    bus_src_decoder_if #(.CODE_W(5), .NUM_SRC(24)) bif0 ();
    bus_src_decoder_if #(.CODE_W(5), .NUM_SRC(24)) bif1 ();

    assign bif0.code       = code_d[0];
    assign bif0.code_valid = vld_d[0];
    assign bif1.code       = code_d[1];
    assign bif1.code_valid = vld_d[1];
    assign rdy_o[0]  = bif0.ready;
    assign sel_o[0]  = bif0.src_sel;
    assign busy_o[0] = bif0.busy;
    assign done_o[0] = bif0.done;
    assign err_o[0]  = bif0.err;
    assign rdy_o[1]  = bif1.ready;
    assign sel_o[1]  = bif1.src_sel;
    assign busy_o[1] = bif1.busy;
    assign done_o[1] = bif1.done;
    assign err_o[1]  = bif1.err;

    bus_src_decoder #(.CODE_W(5), .NUM_SRC(24), .HOLD_CYCLES(HOLD0)) dut0 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bif0.slave)
    );

    bus_src_decoder #(.CODE_W(5), .NUM_SRC(24), .HOLD_CYCLES(HOLD1)) dut1 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bif1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int hold_of(int i);
        return (i == 0) ? int'(HOLD0) : int'(HOLD1);
    endfunction

    function automatic void chk(string name, int i, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; the model decides acceptance from its own view of ready.
    task automatic cycle(bit v0, logic [4:0] c0, bit v1, logic [4:0] c1);
        bit acc [2];
        bit rdy_exp;
        @(negedge clock);
        vld_d[0] = v0; code_d[0] = c0;
        vld_d[1] = v1; code_d[1] = c1;
        #1;
        for (int i = 0; i < 2; i++) begin
            rdy_exp = (rem[i] == 0) || (B2B && rem[i] == 1);
            chk("ready", i, rdy_o[i], rdy_exp);
            acc[i] = vld_d[i] && rdy_exp;
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                exp_t e;
                e.code  = code_d[i];
                e.legal = (code_d[i] < 5'd24);
                q[i].push_back(e);
                rem[i] = e.legal ? hold_of(i) : 0;
            end else if (rem[i] > 0) begin
                rem[i]--;
            end
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic rand_code(output logic [4:0] c);
        if ($urandom_range(0, 99) < 85) c = 5'($urandom_range(0, 23));
        else                            c = 5'($urandom_range(24, 31));
    endtask

    // Pull reset between edges and confirm the enables drop without waiting for a clock.
    task automatic reset_mid;
        @(posedge clock);
        #3;
        clear_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_sel", i, sel_o[i], 0);
            chk("rst_busy", i, busy_o[i], 0);
            chk("rst_done", i, done_o[i], 0);
            chk("rst_ready", i, rdy_o[i], 1);
            q[i].delete();
            rem[i] = 0;
            vld_d[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic mon(int i);
        exp_t e;
        logic [23:0] s;
        s = sel_o[i];
        chk("busy_eq_or", i, busy_o[i], |s);
        chk("onehot0", i, ($countones(s) <= 1), 1);
        chk("done_err_excl", i, done_o[i] & err_o[i], 0);
        if (err_o[i]) begin
            chk("err_has_req", i, q[i].size() != 0, 1);
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                chk("err_code_illegal", i, e.legal, 0);
                chk("err_sel_zero", i, s, 0);
            end
        end
        if (s != '0) begin
            if (!inx[i] || last_done[i]) begin
                chk("xfer_has_req", i, q[i].size() != 0, 1);
                if (q[i].size() != 0) begin
                    e = q[i].pop_front();
                    chk("xfer_legal", i, e.legal, 1);
                    cur[i] = 24'd1 << e.code;
                end
                chk("xfer_sel", i, s, cur[i]);
                inx[i] = 1'b1;
                cnt[i] = 1;
            end else begin
                cnt[i]++;
                chk("hold_sel", i, s, cur[i]);
            end
            chk("done_last", i, done_o[i], cnt[i] == hold_of(i));
        end else begin
            if (inx[i]) chk("no_early_drop", i, last_done[i], 1);
            inx[i] = 1'b0;
            chk("done_idle", i, done_o[i], 0);
        end
        last_done[i] = done_o[i];
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (!clear_n) begin
                for (int i = 0; i < 2; i++) begin
                    inx[i] = 1'b0;
                    last_done[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) mon(i);
            end
        end
    end

    initial begin
        logic [4:0] c0, c1;
        clear_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vld_d[i] = 1'b0; code_d[i] = 5'd0; rem[i] = 0;
            inx[i] = 1'b0; last_done[i] = 1'b0; cnt[i] = 0; cur[i] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_sel", i, sel_o[i], 0);
            chk("reset_busy", i, busy_o[i], 0);
            chk("reset_done", i, done_o[i], 0);
            chk("reset_err", i, err_o[i], 0);
            chk("reset_ready", i, rdy_o[i], 1);
        end
        idle(3);

        // Every legal code once, with enough spacing for the longer hold to finish.
        for (int c = 0; c < 24; c++) begin
            cycle(1'b1, 5'(c), 1'b1, 5'(c));
            idle(HOLD1);
        end

        cycle(1'b1, 5'd24, 1'b1, 5'd24);
        idle(2);
        cycle(1'b1, 5'd31, 1'b1, 5'd31);
        idle(2);

        // Second request while the first is still driving.
        cycle(1'b1, 5'd16, 1'b1, 5'd16);
        cycle(1'b1, 5'd2, 1'b1, 5'd2);
        idle(HOLD1 + 1);

        // Request held on the last drive cycle.
        cycle(1'b1, 5'd1, 1'b1, 5'd1);
        for (int k = 0; k < int'(HOLD1); k++) cycle(1'b1, 5'd21, 1'b1, 5'd21);
        idle(HOLD1 + 1);

        cycle(1'b0, 5'd0, 1'b1, 5'd7);
        reset_mid();
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            rand_code(c0);
            rand_code(c1);
            cycle(1'($urandom_range(0, 1)), c0, 1'($urandom_range(0, 1)), c1);
            if (k == 1500) begin
                cycle(1'b0, 5'd0, 1'b1, 5'd9);
                reset_mid();
            end
        end

        idle(HOLD1 + 3);
        for (int i = 0; i < 2; i++) chk("queue_drained", i, q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
